// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU memory stage, the VGA frame reader, MemDatos and dmem_arbiter.
// The arbiter takes the slave view; the surrounding requesters and memory take the master view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_gnt;
    logic              vga_rvalid;
    logic [DATA_W-1:0] vga_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  vga_req, vga_addr,
        input  mem_rdata,
        output cpu_stall, cpu_rvalid, cpu_rdata,
        output vga_gnt, vga_rvalid, vga_rdata,
        output mem_addr, mem_wdata, mem_we
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output vga_req, vga_addr,
        output mem_rdata,
        input  cpu_stall, cpu_rvalid, cpu_rdata,
        input  vga_gnt, vga_rvalid, vga_rdata,
        input  mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single MemDatos port between the CPU memory stage and the VGA frame reader.
// The CPU wins by default; a saturating wait counter forces a VGA slot after VGA_MAX_WAIT denials.
//
// rd_owner | meaning
// ---------+----------------------------------------------------------
// OWN_NONE | no read in flight; mem_rdata is ignored this cycle
// OWN_CPU  | CPU read issued last cycle; mem_rdata belongs to the CPU
// OWN_VGA  | VGA read issued last cycle; mem_rdata belongs to the VGA
module dmem_arbiter #(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter int VGA_MAX_WAIT = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    dmem_arbiter_if.slave    bus,
    output logic [CNT_W-1:0] conflict_cnt
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VGA  = 2'd2
    } owner_e;

    localparam logic [3:0] WAIT_LIM = 4'(VGA_MAX_WAIT);

    logic [3:0]        wait_cnt_q, wait_cnt_d;
    owner_e            rd_owner_q, rd_owner_d;
    logic [CNT_W-1:0]  conflict_q, conflict_d;
    logic [DATA_W-1:0] cpu_hold_q, cpu_hold_d;
    logic [DATA_W-1:0] vga_hold_q, vga_hold_d;

    logic g_vga;
    logic g_cpu;
    logic stall;
    logic cpu_rvalid;
    logic vga_rvalid;

    always_comb begin
        g_vga = bus.vga_req & (~bus.cpu_req | (wait_cnt_q == WAIT_LIM));
        g_cpu = bus.cpu_req & ~g_vga;
        stall = bus.cpu_req & ~g_cpu;
    end

    assign bus.vga_gnt   = g_vga;
    assign bus.cpu_stall = stall;

    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_we    = 1'b0;
        if (g_cpu) begin
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
            bus.mem_we    = bus.cpu_we;
        end else if (g_vga) begin
            bus.mem_addr = bus.vga_addr;
        end
    end

    // Counter only runs while VGA is actually waiting; dropping the request forfeits the credit.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (g_vga || !bus.vga_req) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q < WAIT_LIM) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_comb begin
        rd_owner_d = OWN_NONE;
        if (g_vga) begin
            rd_owner_d = OWN_VGA;
        end else if (g_cpu && !bus.cpu_we) begin
            rd_owner_d = OWN_CPU;
        end
    end

    always_comb begin
        conflict_d = conflict_q;
        if (stall && (conflict_q != {CNT_W{1'b1}})) begin
            conflict_d = conflict_q + 1'b1;
        end
    end

    assign cpu_rvalid = (rd_owner_q == OWN_CPU);
    assign vga_rvalid = (rd_owner_q == OWN_VGA);

    always_comb begin
        cpu_hold_d = cpu_rvalid ? bus.mem_rdata : cpu_hold_q;
        vga_hold_d = vga_rvalid ? bus.mem_rdata : vga_hold_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            rd_owner_q <= OWN_NONE;
            conflict_q <= '0;
            cpu_hold_q <= '0;
            vga_hold_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rd_owner_q <= rd_owner_d;
            conflict_q <= conflict_d;
            cpu_hold_q <= cpu_hold_d;
            vga_hold_q <= vga_hold_d;
        end
    end

    // The live read bypasses the hold register so data arrives in the rvalid cycle itself.
    assign bus.cpu_rvalid = cpu_rvalid;
    assign bus.vga_rvalid = vga_rvalid;
    assign bus.cpu_rdata  = cpu_rvalid ? bus.mem_rdata : cpu_hold_q;
    assign bus.vga_rdata  = vga_rvalid ? bus.mem_rdata : vga_hold_q;
    assign conflict_cnt   = conflict_q;

    a_one_grant : assert property (@(posedge clk) disable iff (!rst_n) !(g_vga && g_cpu));
    a_wait_bound : assert property (@(posedge clk) disable iff (!rst_n) wait_cnt_q <= WAIT_LIM);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: stimulus pushes expected read returns into a scoreboard,
// a negedge monitor pops and compares them whenever either rvalid is raised.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus_a ();
    dmem_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus_b ();
    logic [15:0] conflict_a;
    logic [1:0]  conflict_b;

    dmem_arbiter #(.ADDR_W(5), .DATA_W(32), .VGA_MAX_WAIT(4), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave), .conflict_cnt(conflict_a));

    dmem_arbiter #(.ADDR_W(5), .DATA_W(32), .VGA_MAX_WAIT(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave), .conflict_cnt(conflict_b));

    logic [31:0] mem [32];
    always @(posedge clk) begin
        if (bus_a.mem_we) mem[bus_a.mem_addr] <= bus_a.mem_wdata;
        bus_a.mem_rdata <= mem[bus_a.mem_addr];
    end
    assign bus_b.mem_rdata = 32'h0;

    typedef struct packed {
        logic        is_vga;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_a.cpu_rvalid || bus_a.vga_rvalid) begin
                chk("rvalid_exclusive", {63'd0, bus_a.cpu_rvalid & bus_a.vga_rvalid}, 64'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_rvalid", {62'd0, bus_a.cpu_rvalid, bus_a.vga_rvalid}, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rd_owner_vga", {63'd0, bus_a.vga_rvalid}, {63'd0, e.is_vga});
                    chk("rd_data", {32'd0, e.is_vga ? bus_a.vga_rdata : bus_a.cpu_rdata},
                        {32'd0, e.data});
                end
            end
        end
    end

    task automatic set_in(input bit creq, input bit cwe, input logic [4:0] caddr,
                          input logic [31:0] cwd, input bit vreq, input logic [4:0] vaddr);
        bus_a.cpu_req   = creq;
        bus_a.cpu_we    = cwe;
        bus_a.cpu_addr  = caddr;
        bus_a.cpu_wdata = cwd;
        bus_a.vga_req   = vreq;
        bus_a.vga_addr  = vaddr;
    endtask

    // One cycle on instance A with hand-computed stall/grant and, for reads, the returned word.
    task automatic step(input bit creq, input bit cwe, input logic [4:0] caddr,
                        input logic [31:0] cwd, input bit vreq, input logic [4:0] vaddr,
                        input bit exp_stall, input bit exp_gnt, input logic [31:0] exp_rd);
        logic       cpu_won;
        logic [4:0] exp_addr;
        set_in(creq, cwe, caddr, cwd, vreq, vaddr);
        cpu_won  = creq & ~exp_stall;
        exp_addr = exp_gnt ? vaddr : (cpu_won ? caddr : 5'd0);
        @(negedge clk);
        chk("cpu_stall", {63'd0, bus_a.cpu_stall}, {63'd0, exp_stall});
        chk("vga_gnt", {63'd0, bus_a.vga_gnt}, {63'd0, exp_gnt});
        chk("mem_we", {63'd0, bus_a.mem_we}, {63'd0, cpu_won & cwe});
        chk("mem_addr", {59'd0, bus_a.mem_addr}, {59'd0, exp_addr});
        if (cpu_won && cwe) chk("mem_wdata", {32'd0, bus_a.mem_wdata}, {32'd0, cwd});
        if (exp_gnt) sb.push_back('{is_vga: 1'b1, data: exp_rd});
        else if (cpu_won && !cwe) sb.push_back('{is_vga: 1'b0, data: exp_rd});
        @(posedge clk);
        #1;
        set_in(0, 0, 5'd0, 32'd0, 0, 5'd0);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 5'd0, 32'd0, 0, 5'd0, 0, 0, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls;
        set_in(0, 0, 5'd0, 32'd0, 0, 5'd0);
        bus_b.cpu_req = 0; bus_b.cpu_we = 0; bus_b.cpu_addr = '0; bus_b.cpu_wdata = '0;
        bus_b.vga_req = 0; bus_b.vga_addr = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("rst_cpu_stall", {63'd0, bus_a.cpu_stall}, 64'd0);
        chk("rst_vga_gnt", {63'd0, bus_a.vga_gnt}, 64'd0);
        chk("rst_cpu_rvalid", {63'd0, bus_a.cpu_rvalid}, 64'd0);
        chk("rst_vga_rvalid", {63'd0, bus_a.vga_rvalid}, 64'd0);
        chk("rst_cpu_rdata", {32'd0, bus_a.cpu_rdata}, 64'd0);
        chk("rst_vga_rdata", {32'd0, bus_a.vga_rdata}, 64'd0);
        chk("rst_mem_we", {63'd0, bus_a.mem_we}, 64'd0);
        chk("rst_mem_addr", {59'd0, bus_a.mem_addr}, 64'd0);
        chk("rst_conflict", {48'd0, conflict_a}, 64'd0);
        @(posedge clk);
        #2;

        // CPU only: write then read back the same word
        step(1, 1, 5'd3, 32'hDEADBEEF, 0, 5'd0, 0, 0, 32'd0);
        step(1, 0, 5'd3, 32'd0,        0, 5'd0, 0, 0, 32'hDEADBEEF);
        idle();
        chk("cpu_rdata_hold", {32'd0, bus_a.cpu_rdata}, {32'd0, 32'hDEADBEEF});

        step(1, 1, 5'd7, 32'h12345678, 0, 5'd0, 0, 0, 32'd0);
        step(1, 1, 5'd1, 32'h000000AA, 0, 5'd0, 0, 0, 32'd0);
        step(1, 1, 5'd2, 32'h000000BB, 0, 5'd0, 0, 0, 32'd0);

        // VGA only
        step(0, 0, 5'd0, 32'd0, 1, 5'd7, 0, 1, 32'h12345678);
        idle();
        chk("vga_rdata_hold", {32'd0, bus_a.vga_rdata}, {32'd0, 32'h12345678});

        // Owner routing: CPU read then VGA read back to back
        step(1, 0, 5'd1, 32'd0, 0, 5'd0, 0, 0, 32'h000000AA);
        step(0, 0, 5'd0, 32'd0, 1, 5'd2, 0, 1, 32'h000000BB);
        idle();
        chk("route_cpu_hold", {32'd0, bus_a.cpu_rdata}, {32'd0, 32'h000000AA});
        chk("route_vga_hold", {32'd0, bus_a.vga_rdata}, {32'd0, 32'h000000BB});
        chk("conflict_pre", {48'd0, conflict_a}, 64'd0);

        // Starvation: CPU x4 then VGA x1, three times
        for (int i = 0; i < 15; i++) begin
            bit vg;
            vg = ((i % 5) == 4);
            step(1, 1, 5'd10, 32'(i), 1, 5'd7, vg, vg, 32'h12345678);
        end
        idle();
        chk("starve_conflict", {48'd0, conflict_a}, 64'd3);
        chk("starve_sb_empty", 64'(sb.size()), 64'd0);

        // Reset while a CPU read is in flight
        set_in(1, 0, 5'd1, 32'd0, 0, 5'd0);
        @(negedge clk);
        chk("mid_stall", {63'd0, bus_a.cpu_stall}, 64'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_conflict_async", {48'd0, conflict_a}, 64'd0);
        set_in(0, 0, 5'd0, 32'd0, 0, 5'd0);
        @(posedge clk);
        #1;
        chk("mid_no_rvalid", {63'd0, bus_a.cpu_rvalid}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_no_rvalid", {63'd0, bus_a.cpu_rvalid}, 64'd0);
        chk("post_rst_cpu_rdata", {32'd0, bus_a.cpu_rdata}, 64'd0);
        @(posedge clk);
        #2;
        idle();

        // Saturation on the CNT_W=2, VGA_MAX_WAIT=1 instance: CPU and VGA alternate
        stalls = 0;
        bus_b.cpu_req = 1; bus_b.cpu_we = 1; bus_b.cpu_addr = 5'd4; bus_b.vga_req = 1;
        for (int i = 0; i < 12; i++) begin
            bit st;
            st = ((i % 2) == 1);
            bus_b.cpu_wdata = 32'(i);
            #1;
            @(negedge clk);
            chk("sat_stall", {63'd0, bus_b.cpu_stall}, {63'd0, st});
            chk("sat_gnt", {63'd0, bus_b.vga_gnt}, {63'd0, st});
            chk("sat_conflict", {62'd0, conflict_b}, 64'((stalls > 3) ? 3 : stalls));
            if (st) stalls++;
            @(posedge clk);
            #1;
        end
        bus_b.cpu_req = 0; bus_b.vga_req = 0;
        @(negedge clk);
        chk("sat_final", {62'd0, conflict_b}, 64'd3);
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
